// File: rtl/instruction_package.sv
// rtl/instruction_package.sv - regex CPU instruction encoding shared by the core and its testbench
package instruction_package;

    localparam int OPCODE_WIDTH   = 3;
    localparam int OPCODE_OFFSET  = 13;
    localparam int OPERAND_WIDTH  = 13;
    localparam int OPERAND_OFFSET = 0;

    typedef enum logic [OPCODE_WIDTH-1:0] {
        ACCEPT                = 3'd0,
        SPLIT                 = 3'd1,
        MATCH_CHAR            = 3'd2,
        NOT_MATCH_CHAR        = 3'd3,
        MATCH_ANY             = 3'd4,
        ACCEPT_PARTIAL        = 3'd5,
        JMP                   = 3'd6,
        END_WITHOUT_ACCEPTING = 3'd7
    } opcode_t;

endpackage

// File: rtl/regex_cpu_pc_fifo.sv
// rtl/regex_cpu_pc_fifo.sv - dual-push single-pop FIFO of {cc_id, pc} successor threads
module regex_cpu_pc_fifo #(
    parameter int PC_WIDTH   = 8,
    parameter int CC_ID_BITS = 2,
    parameter int DEPTH_LOG2 = 2
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      push0_valid,
    input  logic [CC_ID_BITS-1:0]     push0_cc_id,
    input  logic [PC_WIDTH-1:0]       push0_pc,
    input  logic                      push1_valid,
    input  logic [CC_ID_BITS-1:0]     push1_cc_id,
    input  logic [PC_WIDTH-1:0]       push1_pc,
    input  logic                      pop,
    output logic                      head_valid,
    output logic [CC_ID_BITS-1:0]     head_cc_id,
    output logic [PC_WIDTH-1:0]       head_pc,
    output logic [DEPTH_LOG2:0]       free_slots,
    output logic [2**CC_ID_BITS-1:0]  occupied_ccs
);

    localparam int DEPTH = 2 ** DEPTH_LOG2;

    logic [PC_WIDTH-1:0]   mem_pc [DEPTH];
    logic [CC_ID_BITS-1:0] mem_cc [DEPTH];
    logic [DEPTH_LOG2-1:0] rd_ptr;
    logic [DEPTH_LOG2-1:0] wr_ptr;
    logic [DEPTH_LOG2:0]   count;
    logic [DEPTH_LOG2:0]   push_n;
    logic                  do_pop;
    logic [DEPTH_LOG2-1:0] slot_offset;

    assign do_pop     = pop && (count != '0);
    assign push_n     = (DEPTH_LOG2+1)'(push0_valid) + (DEPTH_LOG2+1)'(push1_valid);
    assign head_valid = (count != '0);
    assign head_pc    = head_valid ? mem_pc[rd_ptr] : '0;
    assign head_cc_id = head_valid ? mem_cc[rd_ptr] : '0;
    assign free_slots = (DEPTH_LOG2+1)'(DEPTH) - count;

    // push1 always lands directly behind push0 so a SPLIT pair stays in order
    always_ff @(posedge clk) begin
        if (push0_valid) begin
            mem_pc[wr_ptr] <= push0_pc;
            mem_cc[wr_ptr] <= push0_cc_id;
        end
        if (push1_valid) begin
            mem_pc[wr_ptr + DEPTH_LOG2'(1)] <= push1_pc;
            mem_cc[wr_ptr + DEPTH_LOG2'(1)] <= push1_cc_id;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            count  <= '0;
        end else begin
            wr_ptr <= wr_ptr + DEPTH_LOG2'(push_n);
            if (do_pop) begin
                rd_ptr <= rd_ptr + DEPTH_LOG2'(1);
            end
            count <= count + push_n - (DEPTH_LOG2+1)'(do_pop);
        end
    end

    always_comb begin
        occupied_ccs = '0;
        slot_offset  = '0;
        for (int i = 0; i < DEPTH; i++) begin
            slot_offset = DEPTH_LOG2'(i) - rd_ptr;
            if ({1'b0, slot_offset} < count) begin
                occupied_ccs[mem_cc[i]] = 1'b1;
            end
        end
    end

endmodule

// File: rtl/regex_cpu_pipelined_core.sv
// rtl/regex_cpu_pipelined_core.sv - fetch/execute regex thread CPU with successor-thread output FIFO
module regex_cpu_pipelined_core
    import instruction_package::*;
#(
    parameter int PC_WIDTH              = 8,
    parameter int CHARACTER_WIDTH       = 8,
    parameter int MEMORY_WIDTH          = 16,
    parameter int MEMORY_ADDR_WIDTH     = 11,
    parameter int FIFO_WIDTH_POWER_OF_2 = 2,
    parameter int CC_ID_BITS            = 2
) (
    input  logic                                        clk,
    input  logic                                        rst,
    input  logic [(2**CC_ID_BITS)*CHARACTER_WIDTH-1:0]  current_characters,
    input  logic [(2**CC_ID_BITS)-1:0]                  end_of_string,
    input  logic                                        input_pc_valid,
    input  logic [CC_ID_BITS-1:0]                       input_cc_id,
    input  logic [PC_WIDTH-1:0]                         input_pc,
    output logic                                        input_pc_ready,
    output logic                                        memory_valid,
    input  logic                                        memory_ready,
    output logic [MEMORY_ADDR_WIDTH-1:0]                memory_addr,
    input  logic [MEMORY_WIDTH-1:0]                     memory_data,
    output logic                                        output_pc_valid,
    output logic [CC_ID_BITS-1:0]                       output_cc_id,
    output logic [PC_WIDTH-1:0]                         output_pc,
    input  logic                                        output_pc_ready,
    output logic                                        accepts,
    output logic [(2**CC_ID_BITS)-1:0]                  elaborating_chars,
    output logic                                        running
);

    localparam int N = 2 ** CC_ID_BITS;

    logic                       f_valid;
    logic                       f_issued;
    logic [PC_WIDTH-1:0]        f_pc;
    logic [CC_ID_BITS-1:0]      f_cc;

    logic                       e_valid;
    logic [PC_WIDTH-1:0]        e_pc;
    logic [CC_ID_BITS-1:0]      e_cc;
    opcode_t                    e_opcode;
    logic [PC_WIDTH-1:0]        e_target;
    logic [CHARACTER_WIDTH-1:0] e_char;

    logic [CHARACTER_WIDTH-1:0] cur_char;
    logic                       eos;
    logic                       push0;
    logic                       push1;
    logic [PC_WIDTH-1:0]        push0_pc;
    logic [CC_ID_BITS-1:0]      push0_cc;
    logic                       accept_hit;
    logic [1:0]                 need;
    logic                       e_retire;
    logic                       e_free;
    logic                       mem_issue;
    logic                       fifo_valid;
    logic [FIFO_WIDTH_POWER_OF_2:0] free_slots;
    logic [N-1:0]               fifo_ccs;
    logic                       unused_memory_bits;

    assign unused_memory_bits = ^memory_data;

    assign input_pc_ready = !f_valid;
    assign e_free         = !e_valid || e_retire;
    // a request is only offered once execute can take the word that comes back next cycle
    assign memory_valid   = f_valid && !f_issued && e_free;
    assign memory_addr    = {{(MEMORY_ADDR_WIDTH-PC_WIDTH){1'b0}}, f_pc};
    assign mem_issue      = memory_valid && memory_ready;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            f_valid  <= 1'b0;
            f_issued <= 1'b0;
            f_pc     <= '0;
            f_cc     <= '0;
        end else if (input_pc_valid && input_pc_ready) begin
            f_valid  <= 1'b1;
            f_issued <= 1'b0;
            f_pc     <= input_pc;
            f_cc     <= input_cc_id;
        end else if (f_issued) begin
            f_valid  <= 1'b0;
            f_issued <= 1'b0;
        end else if (mem_issue) begin
            f_issued <= 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            e_valid  <= 1'b0;
            e_pc     <= '0;
            e_cc     <= '0;
            e_opcode <= ACCEPT;
            e_target <= '0;
            e_char   <= '0;
        end else if (f_issued) begin
            e_valid  <= 1'b1;
            e_pc     <= f_pc;
            e_cc     <= f_cc;
            e_opcode <= opcode_t'(memory_data[OPCODE_OFFSET +: OPCODE_WIDTH]);
            e_target <= memory_data[OPERAND_OFFSET +: PC_WIDTH];
            e_char   <= memory_data[OPERAND_OFFSET +: CHARACTER_WIDTH];
        end else if (e_retire) begin
            e_valid  <= 1'b0;
        end
    end

    always_comb begin
        cur_char   = '0;
        for (int i = 0; i < N; i++) begin
            if (e_cc == CC_ID_BITS'(i)) begin
                cur_char = current_characters[i*CHARACTER_WIDTH +: CHARACTER_WIDTH];
            end
        end
        eos        = end_of_string[e_cc];
        push0      = 1'b0;
        push1      = 1'b0;
        push0_pc   = e_pc + PC_WIDTH'(1);
        push0_cc   = e_cc + CC_ID_BITS'(1);
        accept_hit = 1'b0;
        case (e_opcode)
            ACCEPT:         accept_hit = eos;
            SPLIT: begin
                push0    = 1'b1;
                push1    = 1'b1;
                push0_cc = e_cc;
            end
            MATCH_CHAR:     push0 = !eos && (cur_char == e_char);
            NOT_MATCH_CHAR: push0 = !eos && (cur_char != e_char);
            MATCH_ANY:      push0 = !eos;
            ACCEPT_PARTIAL: accept_hit = 1'b1;
            JMP: begin
                push0    = 1'b1;
                push0_pc = e_target;
                push0_cc = e_cc;
            end
            default: ;
        endcase
    end

    // retire only when every successor fits; a pop in the same cycle is not counted as room
    assign need     = {1'b0, push0} + {1'b0, push1};
    assign e_retire = e_valid && (free_slots >= (FIFO_WIDTH_POWER_OF_2+1)'(need));
    assign accepts  = e_retire && accept_hit;

    regex_cpu_pc_fifo #(
        .PC_WIDTH   (PC_WIDTH),
        .CC_ID_BITS (CC_ID_BITS),
        .DEPTH_LOG2 (FIFO_WIDTH_POWER_OF_2)
    ) u_fifo (
        .clk          (clk),
        .rst          (rst),
        .push0_valid  (e_retire && push0),
        .push0_cc_id  (push0_cc),
        .push0_pc     (push0_pc),
        .push1_valid  (e_retire && push1),
        .push1_cc_id  (e_cc),
        .push1_pc     (e_target),
        .pop          (output_pc_ready),
        .head_valid   (fifo_valid),
        .head_cc_id   (output_cc_id),
        .head_pc      (output_pc),
        .free_slots   (free_slots),
        .occupied_ccs (fifo_ccs)
    );

    assign output_pc_valid   = fifo_valid;
    assign running           = f_valid || e_valid || fifo_valid;
    assign elaborating_chars = fifo_ccs
                             | (f_valid ? (N'(1) << f_cc) : '0)
                             | (e_valid ? (N'(1) << e_cc) : '0);

endmodule

// File: tb/tb_regex_cpu_pipelined_core.sv
// tb/tb_regex_cpu_pipelined_core.sv - directed self-checking bench for regex_cpu_pipelined_core
module tb_regex_cpu_pipelined_core;
    import instruction_package::*;

    logic        clk = 1'b0;
    logic        rst;
    logic [31:0] current_characters;
    logic [3:0]  end_of_string;
    logic        input_pc_valid;
    logic [1:0]  input_cc_id;
    logic [7:0]  input_pc;
    logic        input_pc_ready;
    logic        memory_valid;
    logic        memory_ready;
    logic [10:0] memory_addr;
    logic [15:0] memory_data;
    logic        output_pc_valid;
    logic [1:0]  output_cc_id;
    logic [7:0]  output_pc;
    logic        output_pc_ready;
    logic        accepts;
    logic [3:0]  elaborating_chars;
    logic        running;

    int n_checks = 0;
    int n_fail   = 0;
    int acc_cnt  = 0;
    logic [9:0]  got_q [$];
    logic [9:0]  exp_q [$];
    logic [15:0] code_mem [256];
    logic [7:0]  req_addr = 8'h00;

    always #5 clk = ~clk;

    regex_cpu_pipelined_core dut (
        .clk                (clk),
        .rst                (rst),
        .current_characters (current_characters),
        .end_of_string      (end_of_string),
        .input_pc_valid     (input_pc_valid),
        .input_cc_id        (input_cc_id),
        .input_pc           (input_pc),
        .input_pc_ready     (input_pc_ready),
        .memory_valid       (memory_valid),
        .memory_ready       (memory_ready),
        .memory_addr        (memory_addr),
        .memory_data        (memory_data),
        .output_pc_valid    (output_pc_valid),
        .output_cc_id       (output_cc_id),
        .output_pc          (output_pc),
        .output_pc_ready    (output_pc_ready),
        .accepts            (accepts),
        .elaborating_chars  (elaborating_chars),
        .running            (running)
    );

    always @(posedge clk) if (memory_valid && memory_ready) req_addr <= memory_addr[7:0];
    assign memory_data = code_mem[req_addr];

    always @(negedge clk) begin
        if (rst && output_pc_valid && output_pc_ready) got_q.push_back({output_cc_id, output_pc});
        if (rst && accepts) acc_cnt++;
    end

    task automatic step(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic send(input logic [7:0] pc, input logic [1:0] cc);
        bit ok = 0;
        input_pc = pc;
        input_cc_id = cc;
        input_pc_valid = 1'b1;
        for (int k = 0; k < 40; k++) begin
            @(negedge clk);
            if (input_pc_ready) begin ok = 1; break; end
        end
        step(1);
        input_pc_valid = 1'b0;
        n_checks++;
        if (!ok) begin n_fail++; $display("FAIL send_accept pc=%h: input_pc_ready never seen, required 1", pc); end
    endtask

    task automatic wait_outputs(input int n, input int budget);
        for (int k = 0; k < budget; k++) begin
            if (got_q.size() >= n) break;
            @(negedge clk);
        end
        step(1);
        n_checks++;
        if (got_q.size() < n) begin n_fail++; $display("FAIL wait_outputs: got %0d entries, required %0d", got_q.size(), n); end
    endtask

    task automatic run_thread(input logic [7:0] pc, input logic [1:0] cc, input logic [15:0] instr);
        code_mem[pc] = instr;
        got_q.delete();
        acc_cnt = 0;
        send(pc, cc);
        step(8);
    endtask

    task automatic test_reset;
        @(negedge clk);
        n_checks += 6;
        if (input_pc_ready !== 1'b1) begin n_fail++; $display("FAIL reset_ready: got %b, required 1", input_pc_ready); end
        if (memory_valid !== 1'b0) begin n_fail++; $display("FAIL reset_memory_valid: got %b, required 0", memory_valid); end
        if (output_pc_valid !== 1'b0) begin n_fail++; $display("FAIL reset_output_valid: got %b, required 0", output_pc_valid); end
        if (accepts !== 1'b0) begin n_fail++; $display("FAIL reset_accepts: got %b, required 0", accepts); end
        if (running !== 1'b0) begin n_fail++; $display("FAIL reset_running: got %b, required 0", running); end
        if (elaborating_chars !== 4'b0000) begin n_fail++; $display("FAIL reset_elaborating: got %b, required 0000", elaborating_chars); end
        step(1);
    endtask

    task automatic test_split;
        code_mem[8'h05] = {SPLIT, 13'h0020};
        got_q.delete();
        memory_ready = 1'b0;
        send(8'h05, 2'd2);
        @(negedge clk);
        n_checks += 3;
        if (memory_valid !== 1'b1) begin n_fail++; $display("FAIL split_req_valid: got %b, required 1", memory_valid); end
        if (memory_addr !== 11'h005) begin n_fail++; $display("FAIL split_req_addr: got %h, required 005", memory_addr); end
        if (elaborating_chars !== 4'b0100) begin n_fail++; $display("FAIL split_elab_fetch: got %b, required 0100", elaborating_chars); end
        step(1);
        memory_ready = 1'b1;
        step(1);
        memory_ready = 1'b0;
        @(negedge clk);
        n_checks += 2;
        if (memory_valid !== 1'b0) begin n_fail++; $display("FAIL split_req_drop: got %b, required 0", memory_valid); end
        if (output_pc_valid !== 1'b0) begin n_fail++; $display("FAIL split_early_out1: got %b, required 0", output_pc_valid); end
        step(1);
        @(negedge clk);
        n_checks++;
        if (output_pc_valid !== 1'b0) begin n_fail++; $display("FAIL split_early_out2: got %b, required 0", output_pc_valid); end
        step(1);
        @(negedge clk);
        n_checks++;
        if (output_pc_valid !== 1'b1 || output_pc !== 8'h06 || output_cc_id !== 2'd2)
            begin n_fail++; $display("FAIL split_latency: got v=%b pc=%h cc=%0d, required v=1 pc=06 cc=2", output_pc_valid, output_pc, output_cc_id); end
        memory_ready = 1'b1;
        wait_outputs(2, 20);
        step(2);
        @(negedge clk);
        n_checks += 4;
        if (got_q.size() < 2 || got_q[0] !== {2'd2, 8'h06}) begin n_fail++; $display("FAIL split_first: got %h, required 206", got_q.size() > 0 ? got_q[0] : 10'h3ff); end
        if (got_q.size() < 2 || got_q[1] !== {2'd2, 8'h20}) begin n_fail++; $display("FAIL split_second: got %h, required 220", got_q.size() > 1 ? got_q[1] : 10'h3ff); end
        if (running !== 1'b0) begin n_fail++; $display("FAIL split_running: got %b, required 0", running); end
        if (elaborating_chars !== 4'b0000) begin n_fail++; $display("FAIL split_elab_idle: got %b, required 0000", elaborating_chars); end
        step(1);
    endtask

    task automatic test_split_sweep;
        logic [7:0] pc;
        logic [7:0] tgt;
        logic [1:0] cc;
        got_q.delete();
        exp_q.delete();
        for (int i = 0; i < 256; i++) begin
            pc  = 8'(i);
            tgt = 8'((i * 7) % 64);
            cc  = 2'(i % 4);
            code_mem[pc] = {SPLIT, 5'b0, tgt};
            exp_q.push_back({cc, pc + 8'd1});
            exp_q.push_back({cc, tgt});
            send(pc, cc);
        end
        wait_outputs(512, 3000);
        step(10);
        @(negedge clk);
        n_checks += 2;
        if (got_q.size() !== 512) begin n_fail++; $display("FAIL sweep_count: got %0d entries, required 512", got_q.size()); end
        if (running !== 1'b0) begin n_fail++; $display("FAIL sweep_running: got %b, required 0", running); end
        for (int i = 0; i < 512 && i < got_q.size(); i++) begin
            n_checks++;
            if (got_q[i] !== exp_q[i]) begin n_fail++; $display("FAIL sweep_entry %0d: got %h, required %h", i, got_q[i], exp_q[i]); end
        end
        step(1);
    endtask

    task automatic test_match_char;
        current_characters = {8'h61, 8'h00, 8'h00, 8'h00};
        end_of_string = 4'b0000;
        run_thread(8'h10, 2'd3, {MATCH_CHAR, 5'b0, 8'h61});
        n_checks++;
        if (got_q.size() !== 1 || got_q[0] !== {2'd0, 8'h11}) begin n_fail++; $display("FAIL match_hit: got n=%0d %h, required n=1 011", got_q.size(), got_q.size() > 0 ? got_q[0] : 10'h3ff); end
        current_characters = {8'h62, 8'h00, 8'h00, 8'h00};
        run_thread(8'h10, 2'd3, {MATCH_CHAR, 5'b0, 8'h61});
        n_checks += 2;
        if (got_q.size() !== 0) begin n_fail++; $display("FAIL match_miss: got %0d entries, required 0", got_q.size()); end
        if (running !== 1'b0) begin n_fail++; $display("FAIL match_miss_running: got %b, required 0", running); end
        run_thread(8'hFF, 2'd3, {NOT_MATCH_CHAR, 5'b0, 8'h61});
        n_checks++;
        if (got_q.size() !== 1 || got_q[0] !== {2'd0, 8'h00}) begin n_fail++; $display("FAIL not_match_wrap: got n=%0d %h, required n=1 000", got_q.size(), got_q.size() > 0 ? got_q[0] : 10'h3ff); end
        end_of_string = 4'b0100;
        run_thread(8'h12, 2'd2, {MATCH_ANY, 13'h0000});
        n_checks++;
        if (got_q.size() !== 0) begin n_fail++; $display("FAIL any_at_eos: got %0d entries, required 0", got_q.size()); end
        run_thread(8'h13, 2'd1, {JMP, 13'h1F7A});
        n_checks++;
        if (got_q.size() !== 1 || got_q[0] !== {2'd1, 8'h7A}) begin n_fail++; $display("FAIL jmp_target: got n=%0d %h, required n=1 17a", got_q.size(), got_q.size() > 0 ? got_q[0] : 10'h3ff); end
        end_of_string = 4'b0000;
    endtask

    task automatic test_accept;
        end_of_string = 4'b0010;
        run_thread(8'h30, 2'd1, {ACCEPT, 13'h0000});
        n_checks += 2;
        if (acc_cnt !== 1) begin n_fail++; $display("FAIL accept_eos: got %0d pulses, required 1", acc_cnt); end
        if (got_q.size() !== 0) begin n_fail++; $display("FAIL accept_no_output: got %0d entries, required 0", got_q.size()); end
        end_of_string = 4'b0000;
        run_thread(8'h30, 2'd1, {ACCEPT, 13'h0000});
        n_checks++;
        if (acc_cnt !== 0) begin n_fail++; $display("FAIL accept_no_eos: got %0d pulses, required 0", acc_cnt); end
        run_thread(8'h31, 2'd0, {ACCEPT_PARTIAL, 13'h0000});
        n_checks++;
        if (acc_cnt !== 1) begin n_fail++; $display("FAIL accept_partial: got %0d pulses, required 1", acc_cnt); end
        run_thread(8'h32, 2'd0, {END_WITHOUT_ACCEPTING, 13'h0000});
        n_checks++;
        if (acc_cnt !== 0 || got_q.size() !== 0) begin n_fail++; $display("FAIL end_drop: got acc=%0d n=%0d, required 0 0", acc_cnt, got_q.size()); end
    endtask

    task automatic test_back_to_back;
        got_q.delete();
        exp_q.delete();
        output_pc_ready = 1'b0;
        for (int i = 0; i < 4; i++) begin
            code_mem[8'h40 + 8'(i)] = {SPLIT, 5'b0, 8'h80 + 8'(i)};
            exp_q.push_back({2'(i), 8'h41 + 8'(i)});
            exp_q.push_back({2'(i), 8'h80 + 8'(i)});
            send(8'h40 + 8'(i), 2'(i));
        end
        step(10);
        @(negedge clk);
        n_checks += 5;
        if (input_pc_ready !== 1'b0) begin n_fail++; $display("FAIL bp_ready: got %b, required 0", input_pc_ready); end
        if (memory_valid !== 1'b0) begin n_fail++; $display("FAIL bp_memory_valid: got %b, required 0", memory_valid); end
        if (output_pc_valid !== 1'b1) begin n_fail++; $display("FAIL bp_output_valid: got %b, required 1", output_pc_valid); end
        if (elaborating_chars !== 4'b1111) begin n_fail++; $display("FAIL bp_elab: got %b, required 1111", elaborating_chars); end
        if (got_q.size() !== 0) begin n_fail++; $display("FAIL bp_no_pop: got %0d entries, required 0", got_q.size()); end
        step(1);
        output_pc_ready = 1'b1;
        wait_outputs(8, 60);
        step(2);
        n_checks++;
        if (got_q.size() !== 8) begin n_fail++; $display("FAIL bp_drain_count: got %0d, required 8", got_q.size()); end
        for (int i = 0; i < 8 && i < got_q.size(); i++) begin
            n_checks++;
            if (got_q[i] !== exp_q[i]) begin n_fail++; $display("FAIL bp_order %0d: got %h, required %h", i, got_q[i], exp_q[i]); end
        end
    endtask

    task automatic test_async_reset;
        code_mem[8'h50] = {JMP, 13'h0001};
        memory_ready = 1'b0;
        send(8'h50, 2'd3);
        @(negedge clk);
        n_checks++;
        if (memory_valid !== 1'b1) begin n_fail++; $display("FAIL ar_pending: got %b, required 1", memory_valid); end
        #2;
        rst = 1'b0;
        #1;
        n_checks += 4;
        if (memory_valid !== 1'b0) begin n_fail++; $display("FAIL ar_memory_valid: got %b, required 0", memory_valid); end
        if (running !== 1'b0) begin n_fail++; $display("FAIL ar_running: got %b, required 0", running); end
        if (elaborating_chars !== 4'b0000) begin n_fail++; $display("FAIL ar_elab: got %b, required 0000", elaborating_chars); end
        if (output_pc_valid !== 1'b0 || accepts !== 1'b0) begin n_fail++; $display("FAIL ar_outputs: got v=%b a=%b, required 0 0", output_pc_valid, accepts); end
        step(2);
        rst = 1'b1;
        memory_ready = 1'b1;
        @(negedge clk);
        n_checks += 2;
        if (input_pc_ready !== 1'b1) begin n_fail++; $display("FAIL ar_ready_after: got %b, required 1", input_pc_ready); end
        if (running !== 1'b0) begin n_fail++; $display("FAIL ar_idle_after: got %b, required 0", running); end
        step(1);
    endtask

    initial begin
        for (int i = 0; i < 256; i++) code_mem[i] = {END_WITHOUT_ACCEPTING, 13'h0000};
        rst                = 1'b0;
        current_characters = '0;
        end_of_string      = '0;
        input_pc_valid     = 1'b0;
        input_cc_id        = '0;
        input_pc           = '0;
        memory_ready       = 1'b1;
        output_pc_ready    = 1'b1;
        step(3);
        rst = 1'b1;
        test_reset();
        test_split();
        test_split_sweep();
        test_match_char();
        test_accept();
        test_back_to_back();
        test_async_reset();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
